// File: rtl/nibble_serial_sub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg: shared definitions for the nibble-serial subtractor.
//   state_e   - controller state encoding (IDLE / RUN / DONE)
//   SLICE_W   - width of the reused ripple-borrow slice
//   nib_count - number of slice iterations for a given operand width
// ---------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_ctrl_slice.sv
// ---------------------------------------------------------------------------
// nibble_sub_slice: combinational 4-bit ripple-borrow subtractor.
//   a, b  - nibble operands (minuend, subtrahend)
//   bin   - borrow into bit 0
//   diff  - a - b - bin (mod 16)
//   bout  - borrow out of bit 3
// ---------------------------------------------------------------------------
module nibble_sub_slice
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] diff,
  output logic               bout
);

  logic br;

  always_comb begin
    diff = '0;
    br   = bin;
    for (int i = 0; i < SLICE_W; i++) begin
      diff[i] = a[i] ^ b[i] ^ br;
      // Borrow when a<b at this bit, or the bits are equal and a borrow came in.
      br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_sub_ctrl: WIDTH-bit subtractor (A - B - Bin) built from one
// 4-bit ripple-borrow slice reused over WIDTH/4 cycles, LS nibble first.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   - operand handshake (accepted only in IDLE)
//   A, B, Bin           - minuend, subtrahend, borrow-in
//   out_valid/out_ready - result handshake (result held in DONE)
//   Diff, Bor           - difference mod 2^WIDTH, borrow-out of top nibble
//   busy                - high while the slice is iterating (RUN)
//   Zero, Ovf           - only with `define SUB_CMP_FLAGS_EN: result==0 and
//                         signed overflow, registered on entry to DONE
// ---------------------------------------------------------------------------
module nibble_serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bor,
`ifdef SUB_CMP_FLAGS_EN
  output logic             Zero,
  output logic             Ovf,
`endif
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("nibble_serial_sub_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bor_q, bor_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef SUB_CMP_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] s_a, s_b, s_diff;
  logic               s_bout;
  logic [31:0]        sh;

  // Bit offset of the nibble currently being processed.
  assign sh  = SLICE_W * 32'(idx_q);
  assign s_a = SLICE_W'(a_q >> sh);
  assign s_b = SLICE_W'(b_q >> sh);

  nibble_sub_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (borrow_q),
    .diff (s_diff),
    .bout (s_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bor_d    = bor_q;
    idx_d    = idx_q;
`ifdef SUB_CMP_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          diff_d   = '0;
          bor_d    = 1'b0;
`ifdef SUB_CMP_FLAGS_EN
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
`endif
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Merge the slice result into its nibble position; the accumulator
        // was cleared on accept so only this nibble changes.
        diff_d   = (diff_q & ~({{(WIDTH-SLICE_W){1'b0}}, {SLICE_W{1'b1}}} << sh))
                 | ({{(WIDTH-SLICE_W){1'b0}}, s_diff} << sh);
        borrow_d = s_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          bor_d   = s_bout;
          idx_d   = '0;
`ifdef SUB_CMP_FLAGS_EN
          zero_d  = (diff_d == '0);
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_diff[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bor_q    <= 1'b0;
      idx_q    <= '0;
`ifdef SUB_CMP_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bor_q    <= bor_d;
      idx_q    <= idx_d;
`ifdef SUB_CMP_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign Diff      = diff_q;
  assign Bor       = bor_q;
`ifdef SUB_CMP_FLAGS_EN
  assign Zero      = zero_q;
  assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for nibble_serial_sub_ctrl (WIDTH=32). Expected results come from
// plain 33-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_nibble_serial_sub_ctrl;

  localparam int W   = 32;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Bor;
  logic         busy;
`ifdef SUB_CMP_FLAGS_EN
  logic         Zero, Ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  nibble_serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bor       (Bor),
`ifdef SUB_CMP_FLAGS_EN
    .Zero      (Zero),
    .Ovf       (Ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: unsigned A - B - Bin with the borrow as bit W.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return r;
  endfunction

  // Full transaction: present operands, measure latency, check result, drain.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin);
    logic [W:0] exp;
    int lat;
    exp = ref_sub(a, b, bin);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready_idle: got %b want 1", name, in_ready);
    end
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Bin = 1'($urandom);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s run_flags: busy %b in_ready %b want 1/0", name, busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
    n_cmp++;
    if (Diff !== exp[W-1:0] || Bor !== exp[W]) begin
      n_fail++; $display("FAIL %s result: got %h/%b want %h/%b", name, Diff, Bor, exp[W-1:0], exp[W]);
    end
`ifdef SUB_CMP_FLAGS_EN
    n_cmp++;
    if (Zero !== (exp[W-1:0] == '0) ||
        Ovf !== ((a[W-1] != b[W-1]) && (exp[W-1] != a[W-1]))) begin
      n_fail++; $display("FAIL %s flags: got Z%b O%b want Z%b O%b", name, Zero, Ovf,
                         (exp[W-1:0] == '0), ((a[W-1] != b[W-1]) && (exp[W-1] != a[W-1])));
    end
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Diff !== exp[W-1:0] || Bor !== exp[W]) begin
      n_fail++; $display("FAIL %s drain: ov %b ir %b diff %h bor %b want 0/1/%h/%b",
                         name, out_valid, in_ready, Diff, Bor, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || Diff !== '0 || Bor !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: ir %b ov %b busy %b diff %h bor %b want 1/0/0/0/0",
                         in_ready, out_valid, busy, Diff, Bor);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("small",      32'h0000_0005, 32'h0000_0003, 1'b0);
    run_op("full_borrow", 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("bin_chain",  32'h1000_0000, 32'h0000_0001, 1'b1);
    run_op("equal_bin",  32'hABCD_1234, 32'hABCD_1234, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op("random", 32'($urandom), 32'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    logic [W-1:0] na, nb;
    int lat;
    exp = ref_sub(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; Bin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      A = $urandom; B = $urandom; Bin = 1'($urandom); in_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Diff !== exp[W-1:0] || Bor !== exp[W]) begin
        n_fail++; $display("FAIL bp_hold: ov %b ir %b diff %h bor %b want 1/0/%h/%b",
                           out_valid, in_ready, Diff, Bor, exp[W-1:0], exp[W]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Diff !== exp[W-1:0]) begin
      n_fail++; $display("FAIL bp_release: ir %b ov %b diff %h want 1/0/%h",
                         in_ready, out_valid, Diff, exp[W-1:0]);
    end
    na = 32'($urandom); nb = 32'($urandom);
    run_op("after_bp", na, nb, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A = 32'h8765_4321; B = 32'h1111_1111; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);   // three slice steps done, idx now 3
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || Diff !== '0 || Bor !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: ov %b ir %b busy %b diff %h bor %b want 0/1/0/0/0",
                         out_valid, in_ready, busy, Diff, Bor);
    end
    @(negedge clk);
    rst = 1'b0;
    // Partial result must not surface as out_valid later.
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_result: out_valid %b want 0", out_valid);
    end
    run_op("post_reset", 32'hFFFF_FFFF, 32'h0000_000F, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op("b2b", 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 1'($urandom));
    end
  endtask

`ifdef SUB_CMP_FLAGS_EN
  task automatic test_flags();
    run_op("flag_zero", 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op("flag_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op("flag_ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SUB_CMP_FLAGS_EN
    test_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
